branch_predictor_bht: RTL and testbench
=======================================

// Module: branch_predictor_bht
// PURPOSE
//   Direct-mapped branch history table + branch target buffer. Generates the
//   fetch-time prediction (Predict_Taken, target) that enters the pipeline at IF
//   and travels to EX through the IF/ID and ID/EX registers. Consumes the
//   resolved outcome back from EX to train 2-bit saturating counters and targets.
//   Keeps saturating branch and direction-mispredict statistics counters.
// PARAMETERS
//   DATA_WIDTH  32  PC / target width
//   INDEX_BITS  6   table index width; 2**INDEX_BITS entries
//   TAG_BITS    8   partial tag width stored per entry
//   CNT_WIDTH   32  statistics counter width
// PORTS
//   clk                in   1           clock, all state on rising edge
//   rst                in   1           synchronous reset, active-high
//   IF_PC              in   DATA_WIDTH  fetch PC to predict
//   IF_Predict_Taken   out  1           prediction for IF_PC, same cycle
//   IF_Predict_Target  out  DATA_WIDTH  next fetch PC if predicted taken, else IF_PC+4
//   EX_Update_en       in   1           resolved JAL or conditional branch in EX, not flushed
//   EX_Is_Jump         in   1           update is JAL (unconditional)
//   EX_PC              in   DATA_WIDTH  PC of resolved instruction
//   EX_Taken           in   1           actual direction
//   EX_Target          in   DATA_WIDTH  actual taken target
//   EX_Predict_Taken   in   1           prediction that travelled with the instruction
//   EX_Mispredict      out  1           direction mispredict flag, combinational
//   Stat_Branches      out  CNT_WIDTH   count of accepted updates
//   Stat_Mispredicts   out  CNT_WIDTH   count of direction mispredicts
// BEHAVIOUR
//   - Entry state: valid(1), tag(TAG_BITS), ctr(2), target(DATA_WIDTH).
//   - idx = PC[INDEX_BITS+1:2]; tag = PC[INDEX_BITS+TAG_BITS+1:INDEX_BITS+2].
//   - Reset (rst high at an edge): all valid=0, ctr=2'b01, target=0, both stats=0.
//     Reset wins over a same-cycle update. Outputs after reset:
//     IF_Predict_Taken=0, IF_Predict_Target=IF_PC+4, EX_Mispredict per inputs.
//   - Lookup, combinational, 0-cycle: hit = valid[idx] & tag match;
//     IF_Predict_Taken = hit & ctr[1]; target = taken ? entry target : IF_PC+4 (mod 2**DATA_WIDTH).
//   - EX_Mispredict = EX_Update_en & (EX_Taken != EX_Predict_Taken).
//     Target-only mismatch from partial-tag aliasing is not flagged.
//   - Update, 1-cycle latency, on edge with EX_Update_en=1:
//     hit, JAL: ctr=2'b11, target=EX_Target.
//     hit, branch taken: ctr=min(ctr+1,3), target=EX_Target.
//     hit, branch not taken: ctr=max(ctr-1,0), target unchanged.
//     miss, taken: allocate/overwrite entry: valid=1, tag, target=EX_Target,
//       ctr=2'b11 for JAL, 2'b10 for branch.
//     miss, not taken: no change.
//   - JALR must never drive EX_Update_en; EX resolves JALR without the predictor.
//   - Same-cycle lookup and update to the same idx is read-before-write:
//     the lookup sees the old entry, and the new entry is visible the next cycle.
//   - Stats: Stat_Branches+1 on each update, Stat_Mispredicts+1 when EX_Mispredict=1.
//     Both saturate at all-ones and never wrap.
// TESTING
//   - Reset, then IF_PC=0x100 -> Predict_Taken=0, Target=0x104, stats=0.
//   - Branch PC=0x100 taken to 0x80, Predict=0 -> Mispredict=1.
//     Next cycle: IF_PC=0x100 gives Taken=1, Target=0x80; Stat_Mispredicts=1.
//   - Same branch: 3 not-taken updates -> ctr 10->01->00->00 (saturates).
//     Prediction 0 after the first update; a taken update then gives ctr=01, still predicts 0.
//   - JAL PC=0x200 to 0x40 on a miss -> ctr=11, Predict_Taken=1.
//     PC=0x200+(1<<(INDEX_BITS+2)) (same idx, other tag) -> miss, Target=PC+4.
//   - Update and lookup of PC=0x300 in the same cycle -> old prediction returned, new one next cycle.
//     rst asserted together with an update -> entry stays invalid.
//   - Force Stat_Mispredicts to all-ones via long mispredict run -> holds all-ones.

Source files
------------

// File: rtl/branch_predictor_bht.sv
// rtl/branch_predictor_bht.sv - direct-mapped BHT/BTB with 2-bit counters and stats
// Combinational fetch-time lookup; EX-stage training one cycle later; saturating stats.
module branch_predictor_bht #(
  parameter int DATA_WIDTH = 32,
  parameter int INDEX_BITS = 6,
  parameter int TAG_BITS   = 8,
  parameter int CNT_WIDTH  = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [DATA_WIDTH-1:0] IF_PC,
  output logic                  IF_Predict_Taken,
  output logic [DATA_WIDTH-1:0] IF_Predict_Target,
  input  logic                  EX_Update_en,
  input  logic                  EX_Is_Jump,
  input  logic [DATA_WIDTH-1:0] EX_PC,
  input  logic                  EX_Taken,
  input  logic [DATA_WIDTH-1:0] EX_Target,
  input  logic                  EX_Predict_Taken,
  output logic                  EX_Mispredict,
  output logic [CNT_WIDTH-1:0]  Stat_Branches,
  output logic [CNT_WIDTH-1:0]  Stat_Mispredicts
);

  localparam int ENTRIES = 2 ** INDEX_BITS;
  localparam int TAG_LSB = INDEX_BITS + 2;
  localparam int TAG_MSB = INDEX_BITS + TAG_BITS + 1;

  logic                  valid_q [ENTRIES];
  logic [TAG_BITS-1:0]   tag_q   [ENTRIES];
  logic [1:0]            ctr_q   [ENTRIES];
  logic [DATA_WIDTH-1:0] tgt_q   [ENTRIES];
  logic [CNT_WIDTH-1:0]  branches_q, branches_d;
  logic [CNT_WIDTH-1:0]  mispred_q, mispred_d;

  logic [INDEX_BITS-1:0] if_idx, ex_idx;
  logic [TAG_BITS-1:0]   if_tag, ex_tag;
  logic                  if_hit, ex_hit;

  logic                  upd_we;
  logic [1:0]            upd_ctr_d;
  logic [DATA_WIDTH-1:0] upd_tgt_d;

  // Low PC bits and bits above the tag take no part in indexing or tagging.
  logic unused_ex_pc;
  assign unused_ex_pc = ^{EX_PC[1:0], EX_PC[DATA_WIDTH-1:TAG_MSB+1]};

  assign if_idx = IF_PC[INDEX_BITS+1:2];
  assign if_tag = IF_PC[TAG_MSB:TAG_LSB];
  assign ex_idx = EX_PC[INDEX_BITS+1:2];
  assign ex_tag = EX_PC[TAG_MSB:TAG_LSB];

  assign if_hit = valid_q[if_idx] && (tag_q[if_idx] == if_tag);
  assign ex_hit = valid_q[ex_idx] && (tag_q[ex_idx] == ex_tag);

  assign IF_Predict_Taken  = if_hit && ctr_q[if_idx][1];
  assign IF_Predict_Target = IF_Predict_Taken ? tgt_q[if_idx] : IF_PC + DATA_WIDTH'(4);

  assign EX_Mispredict = EX_Update_en && (EX_Taken != EX_Predict_Taken);

  always_comb begin
    upd_we    = 1'b0;
    upd_ctr_d = ctr_q[ex_idx];
    upd_tgt_d = tgt_q[ex_idx];
    if (EX_Update_en) begin
      if (ex_hit) begin
        upd_we = 1'b1;
        if (EX_Is_Jump) begin
          upd_ctr_d = 2'b11;
          upd_tgt_d = EX_Target;
        end else if (EX_Taken) begin
          upd_ctr_d = (ctr_q[ex_idx] == 2'b11) ? 2'b11 : ctr_q[ex_idx] + 2'd1;
          upd_tgt_d = EX_Target;
        end else begin
          upd_ctr_d = (ctr_q[ex_idx] == 2'b00) ? 2'b00 : ctr_q[ex_idx] - 2'd1;
        end
      end else if (EX_Taken) begin
        // Miss on a taken transfer allocates, evicting any aliasing entry.
        upd_we    = 1'b1;
        upd_ctr_d = EX_Is_Jump ? 2'b11 : 2'b10;
        upd_tgt_d = EX_Target;
      end
    end
  end

  always_comb begin
    branches_d = branches_q;
    mispred_d  = mispred_q;
    if (EX_Update_en && (branches_q != {CNT_WIDTH{1'b1}})) branches_d = branches_q + CNT_WIDTH'(1);
    if (EX_Mispredict && (mispred_q != {CNT_WIDTH{1'b1}})) mispred_d = mispred_q + CNT_WIDTH'(1);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < ENTRIES; i++) begin
        valid_q[i] <= 1'b0;
        tag_q[i]   <= '0;
        ctr_q[i]   <= 2'b01;
        tgt_q[i]   <= '0;
      end
      branches_q <= '0;
      mispred_q  <= '0;
    end else begin
      if (upd_we) begin
        valid_q[ex_idx] <= 1'b1;
        tag_q[ex_idx]   <= ex_tag;
        ctr_q[ex_idx]   <= upd_ctr_d;
        tgt_q[ex_idx]   <= upd_tgt_d;
      end
      branches_q <= branches_d;
      mispred_q  <= mispred_d;
    end
  end

  assign Stat_Branches    = branches_q;
  assign Stat_Mispredicts = mispred_q;

endmodule

// File: tb/tb_branch_predictor_bht.sv
// tb/tb_branch_predictor_bht.sv - directed self-checking bench for branch_predictor_bht
// Narrow statistics counters make saturation reachable in a short run.
module tb_branch_predictor_bht;

  localparam int DW = 32;
  localparam int CW = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic [DW-1:0] IF_PC;
  logic          IF_Predict_Taken;
  logic [DW-1:0] IF_Predict_Target;
  logic          EX_Update_en, EX_Is_Jump, EX_Taken, EX_Predict_Taken;
  logic [DW-1:0] EX_PC, EX_Target;
  logic          EX_Mispredict;
  logic [CW-1:0] Stat_Branches, Stat_Mispredicts;

  int checks = 0;
  int errors = 0;

  branch_predictor_bht #(.DATA_WIDTH(DW), .INDEX_BITS(6), .TAG_BITS(8), .CNT_WIDTH(CW)) dut (
    .clk(clk), .rst(rst), .IF_PC(IF_PC),
    .IF_Predict_Taken(IF_Predict_Taken), .IF_Predict_Target(IF_Predict_Target),
    .EX_Update_en(EX_Update_en), .EX_Is_Jump(EX_Is_Jump), .EX_PC(EX_PC),
    .EX_Taken(EX_Taken), .EX_Target(EX_Target), .EX_Predict_Taken(EX_Predict_Taken),
    .EX_Mispredict(EX_Mispredict),
    .Stat_Branches(Stat_Branches), .Stat_Mispredicts(Stat_Mispredicts)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic upd(input logic jmp, input logic [DW-1:0] pc, input logic tk,
                     input logic [DW-1:0] tgt, input logic pred);
    EX_Update_en = 1'b1; EX_Is_Jump = jmp; EX_PC = pc;
    EX_Taken = tk; EX_Target = tgt; EX_Predict_Taken = pred;
  endtask

  task automatic idle();
    EX_Update_en = 1'b0; EX_Is_Jump = 1'b0; EX_Taken = 1'b0; EX_Predict_Taken = 1'b0;
  endtask

  initial begin
    rst = 1'b1; IF_PC = 32'h100; EX_PC = '0; EX_Target = '0;
    idle();
    tick(); tick();
    rst = 1'b0;
    #1;
    chk("reset_taken", {31'b0, IF_Predict_Taken}, 32'd0);
    chk("reset_target", IF_Predict_Target, 32'h104);
    chk("reset_branches", {28'b0, Stat_Branches}, 32'd0);
    chk("reset_mispreds", {28'b0, Stat_Mispredicts}, 32'd0);
    EX_Taken = 1'b1; EX_Predict_Taken = 1'b0;
    #1;
    chk("mispred_gated_by_en", {31'b0, EX_Mispredict}, 32'd0);

    // Miss, branch taken -> allocate with ctr=10
    upd(1'b0, 32'h100, 1'b1, 32'h80, 1'b0);
    #1;
    chk("alloc_mispredict", {31'b0, EX_Mispredict}, 32'd1);
    chk("alloc_rbw_old_taken", {31'b0, IF_Predict_Taken}, 32'd0);
    tick(); idle(); #1;
    chk("alloc_taken", {31'b0, IF_Predict_Taken}, 32'd1);
    chk("alloc_target", IF_Predict_Target, 32'h80);
    chk("alloc_mispreds", {28'b0, Stat_Mispredicts}, 32'd1);
    chk("alloc_branches", {28'b0, Stat_Branches}, 32'd1);

    // Three not-taken: 10 -> 01 -> 00 -> 00
    upd(1'b0, 32'h100, 1'b0, 32'h0, 1'b1);
    #1;
    chk("nt1_mispredict", {31'b0, EX_Mispredict}, 32'd1);
    tick(); #1;
    chk("nt1_taken", {31'b0, IF_Predict_Taken}, 32'd0);
    chk("nt1_target", IF_Predict_Target, 32'h104);
    upd(1'b0, 32'h100, 1'b0, 32'h0, 1'b0);
    #1;
    chk("nt2_no_mispredict", {31'b0, EX_Mispredict}, 32'd0);
    tick(); tick(); #1;
    chk("nt3_taken", {31'b0, IF_Predict_Taken}, 32'd0);
    // Taken from 00 -> 01: still not predicted taken
    upd(1'b0, 32'h100, 1'b1, 32'h90, 1'b0);
    tick(); idle(); #1;
    chk("t_from_00_taken", {31'b0, IF_Predict_Taken}, 32'd0);
    chk("t_from_00_target", IF_Predict_Target, 32'h104);
    chk("seq_branches", {28'b0, Stat_Branches}, 32'd5);
    chk("seq_mispreds", {28'b0, Stat_Mispredicts}, 32'd3);
    // Second taken: 01 -> 10, target is the latest
    upd(1'b0, 32'h100, 1'b1, 32'h90, 1'b0);
    tick(); idle(); #1;
    chk("t_from_01_taken", {31'b0, IF_Predict_Taken}, 32'd1);
    chk("t_from_01_target", IF_Predict_Target, 32'h90);

    // JAL miss at 0x200 -> ctr 11
    IF_PC = 32'h200;
    upd(1'b1, 32'h200, 1'b1, 32'h40, 1'b0);
    tick(); idle(); #1;
    chk("jal_taken", {31'b0, IF_Predict_Taken}, 32'd1);
    chk("jal_target", IF_Predict_Target, 32'h40);
    IF_PC = 32'h300;
    #1;
    chk("alias_miss_taken", {31'b0, IF_Predict_Taken}, 32'd0);
    chk("alias_miss_target", IF_Predict_Target, 32'h304);

    // Same-cycle update and lookup at 0x300
    upd(1'b0, 32'h300, 1'b1, 32'h500, 1'b0);
    #1;
    chk("rbw_old_taken", {31'b0, IF_Predict_Taken}, 32'd0);
    chk("rbw_old_target", IF_Predict_Target, 32'h304);
    tick(); idle(); #1;
    chk("rbw_new_taken", {31'b0, IF_Predict_Taken}, 32'd1);
    chk("rbw_new_target", IF_Predict_Target, 32'h500);
    IF_PC = 32'h200;
    #1;
    chk("evicted_taken", {31'b0, IF_Predict_Taken}, 32'd0);
    chk("stats_branches_8", {28'b0, Stat_Branches}, 32'd8);
    chk("stats_mispreds_6", {28'b0, Stat_Mispredicts}, 32'd6);

    // Reset wins over a same-cycle update
    rst = 1'b1;
    upd(1'b1, 32'h400, 1'b1, 32'h44, 1'b0);
    tick(); rst = 1'b0; idle();
    IF_PC = 32'h400;
    #1;
    chk("rst_upd_taken", {31'b0, IF_Predict_Taken}, 32'd0);
    chk("rst_upd_target", IF_Predict_Target, 32'h404);
    IF_PC = 32'h300;
    #1;
    chk("rst_clears_old", {31'b0, IF_Predict_Taken}, 32'd0);
    chk("rst_stats_branches", {28'b0, Stat_Branches}, 32'd0);
    chk("rst_stats_mispreds", {28'b0, Stat_Mispredicts}, 32'd0);

    // Saturation: not-taken misses at 0x600 mispredict without touching the table
    upd(1'b0, 32'h600, 1'b0, 32'h0, 1'b1);
    for (int i = 0; i < 14; i++) tick();
    chk("sat_pre_mispreds", {28'b0, Stat_Mispredicts}, 32'd14);
    for (int i = 0; i < 6; i++) tick();
    idle(); #1;
    chk("sat_mispreds", {28'b0, Stat_Mispredicts}, 32'd15);
    chk("sat_branches", {28'b0, Stat_Branches}, 32'd15);
    IF_PC = 32'h600;
    #1;
    chk("nt_miss_no_alloc", {31'b0, IF_Predict_Taken}, 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
